exp_sched: RTL and testbench

Round-robin scheduler that shares one left-to-right exponentiation engine (control unit plus datapath) between `N_REQ` requesters. It accepts `base`/`exp` operand pairs over per-requester valid/ready handshakes and launches the engine with a single start pulse. It collects the result on `done` and returns it on a single tagged response channel. Only one operation is outstanding at a time. The block sits between the requesting clients and the engine top level; the engine shares `clk` and `rst`.

---
 rtl/exp_sched_pkg.sv | 18 +
 rtl/exp_sched_rr_pick.sv | 31 +++
 rtl/exp_sched.sv | 109 ++++++++++
 tb/tb_exp_sched.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_sched_pkg.sv
// Shared types and constants for the exponentiation-engine scheduler.
package exp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int             CYC_W   = 16;
  localparam logic [CYC_W-1:0] CYC_MAX = 16'hFFFF;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == CYC_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/exp_sched_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req_valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/exp_sched.sv
// Round-robin scheduler sharing one exponentiation engine between N_REQ requesters.
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_base,
  input  logic [N_REQ*WIDTH-1:0] req_exp,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDX_W-1:0]       resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic [CYC_W-1:0]       resp_cycles,
  output logic                   eng_start,
  output logic [WIDTH-1:0]       eng_base,
  output logic [WIDTH-1:0]       eng_exp,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_result,
  output logic                   err_spurious
);

  state_t           state, next_state;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] sel_base, sel_exp;
  logic             grant_fire;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  assign sel_base   = req_base[pick_idx*WIDTH +: WIDTH];
  assign sel_exp    = req_exp[pick_idx*WIDTH +: WIDTH];
  assign grant_fire = (state == IDLE) && pick_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // exp==0 needs no engine pass, so the grant goes straight to RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_any) next_state = (sel_exp == '0) ? RESP : START;
      START:   next_state = WAIT;
      WAIT:    if (eng_done) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grants are masked during reset so every output reads zero while rst is high.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    eng_start  = 1'b0;
    case (state)
      IDLE:    if (!rst) req_ready = pick_grant;
      START:   eng_start = 1'b1;
      WAIT:    ;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      resp_id      <= '0;
      resp_data    <= '0;
      resp_cycles  <= '0;
      eng_base     <= '0;
      eng_exp      <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (grant_fire) begin
        resp_id  <= pick_idx;
        eng_base <= sel_base;
        eng_exp  <= sel_exp;
        ptr      <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        if (sel_exp == '0) begin
          resp_data   <= WIDTH'(1);
          resp_cycles <= '0;
        end
      end
      if (state == START) resp_cycles <= '0;
      // The done cycle itself is counted as a busy cycle.
      if (state == WAIT) begin
        resp_cycles <= sat_inc(resp_cycles);
        if (eng_done) resp_data <= eng_result;
      end
      if (eng_done && (state != WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_sched.sv
// Self-checking bench for exp_sched with a behavioural engine and scheduler model.
module tb_exp_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_base;
  logic [31:0] req_exp;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic [15:0] resp_cycles;
  logic        eng_start;
  logic [7:0]  eng_base;
  logic [7:0]  eng_exp;
  logic        eng_done;
  logic [7:0]  eng_result;
  logic        err_spurious;

  logic        model_done;
  logic        spur_done;
  int          eng_delay;
  int          n_starts;
  logic [7:0]  eng_res_q;
  bit          eng_abort;
  int          tests_run;
  int          tests_failed;
  int          model_ptr;
  logic [7:0]  op_base [4];
  logic [7:0]  op_exp  [4];

  assign eng_done = model_done | spur_done;

  exp_sched #(.N_REQ(4), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base     (req_base),
    .req_exp      (req_exp),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_cycles  (resp_cycles),
    .eng_start    (eng_start),
    .eng_base     (eng_base),
    .eng_exp      (eng_exp),
    .eng_done     (eng_done),
    .eng_result   (eng_result),
    .err_spurious (err_spurious)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_pow(input logic [7:0] b, input logic [7:0] e);
    logic [7:0] r;
    r = 8'd1;
    for (int i = 0; i < int'(e); i++) r = r * b;
    return r;
  endfunction

  function automatic int ref_pick(input int p, input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (((mask >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v == (4'd1 << i)) return i;
    return -1;
  endfunction

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_base[i*8 +: 8] = op_base[i];
      req_exp[i*8 +: 8]  = op_exp[i];
    end
  endtask

  // Engine model: result = base**exp mod 256, done pulse eng_delay cycles after start.
  initial begin
    model_done = 1'b0;
    eng_result = 8'd0;
    n_starts   = 0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1 && rst === 1'b0) begin
        n_starts++;
        eng_res_q = ref_pow(eng_base, eng_exp);
        eng_abort = 1'b0;
        for (int i = 0; i < eng_delay; i++) begin
          @(posedge clk);
          if (rst) begin
            eng_abort = 1'b1;
            break;
          end
        end
        if (!eng_abort) begin
          #1;
          model_done = 1'b1;
          eng_result = eng_res_q;
          @(posedge clk);
          #1;
          model_done = 1'b0;
        end
      end
    end
  end

  task automatic run_txn(input logic [3:0] mask, input int delay);
    int pred, n, starts0, exp_lat, exp_starts;
    bit got, seen;
    logic [7:0]  exp_data;
    logic [15:0] exp_cyc;
    @(posedge clk);
    #1;
    eng_delay = delay;
    load_ops();
    req_valid = mask;
    pred       = ref_pick(model_ptr, mask);
    exp_data   = (op_exp[pred] == 8'd0) ? 8'd1 : ref_pow(op_base[pred], op_exp[pred]);
    exp_cyc    = (op_exp[pred] == 8'd0) ? 16'd0 : ((delay > 65535) ? 16'hFFFF : 16'(delay));
    exp_lat    = (op_exp[pred] == 8'd0) ? 1 : delay + 2;
    exp_starts = (op_exp[pred] == 8'd0) ? 0 : 1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got || req_ready !== (4'd1 << pred)) begin
      tests_failed++;
      $display("FAIL txn_grant: req_ready=%b required=%b", req_ready, 4'd1 << pred);
    end
    starts0 = n_starts;
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    model_ptr = (pred + 1) % 4;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < exp_lat + 20; c++) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || n != exp_lat) begin
      tests_failed++;
      $display("FAIL txn_latency: got %0d cycles (seen=%0d) required %0d", n, seen, exp_lat);
    end
    tests_run++;
    if (resp_id !== 2'(pred) || resp_data !== exp_data || resp_cycles !== exp_cyc) begin
      tests_failed++;
      $display("FAIL txn_resp: id=%0d data=%0d cycles=%0d required id=%0d data=%0d cycles=%0d",
               resp_id, resp_data, resp_cycles, pred, exp_data, exp_cyc);
    end
    tests_run++;
    if (n_starts - starts0 != exp_starts) begin
      tests_failed++;
      $display("FAIL txn_starts: got %0d eng_start pulses required %0d", n_starts - starts0, exp_starts);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_id, resp_data, resp_cycles, eng_start, eng_base, eng_exp, err_spurious} !== 49'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: some output nonzero during reset, resp_valid=%b req_ready=%b", resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, eng_start, err_spurious} !== 7'd0 || dut.ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: req_ready=%b resp_valid=%b eng_start=%b ptr=%0d required all 0",
               req_ready, resp_valid, eng_start, dut.ptr);
    end
    model_ptr = 0;
  endtask

  task automatic test_fairness();
    int order1[$];
    int order2[$];
    int exp1[5] = '{0, 1, 2, 3, 0};
    int exp2[3] = '{1, 3, 1};
    int g;
    for (int i = 0; i < 4; i++) begin
      op_base[i] = 8'($urandom);
      op_exp[i]  = 8'($urandom_range(1, 5));
    end
    @(posedge clk);
    #1;
    eng_delay = 2;
    load_ops();
    req_valid = 4'hF;
    for (int c = 0; c < 200 && order1.size() < 5; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) order1.push_back(onehot_idx(req_ready));
    end
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    for (int c = 0; c < 200 && order2.size() < 3; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) order2.push_back(onehot_idx(req_ready));
    end
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      g = (order1.size() > i) ? order1[i] : -1;
      tests_run++;
      if (g != exp1[i]) begin
        tests_failed++;
        $display("FAIL fair_all grant %0d: got %0d required %0d", i, g, exp1[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      g = (order2.size() > i) ? order2[i] : -1;
      tests_run++;
      if (g != exp2[i]) begin
        tests_failed++;
        $display("FAIL fair_1_3 grant %0d: got %0d required %0d", i, g, exp2[i]);
      end
    end
    model_ptr = 2;
  endtask

  task automatic test_single();
    op_base[2] = 8'd3;
    op_exp[2]  = 8'd5;
    run_txn(4'b0100, 20);
  endtask

  task automatic test_exp_zero();
    op_base[0] = 8'd7;
    op_exp[0]  = 8'd0;
    run_txn(4'b0001, 5);
  endtask

  task automatic test_backpressure();
    int pred;
    bit got, seen, stable_ok, ready_ok;
    logic [7:0] d3, d1;
    op_base[3] = 8'($urandom);
    op_exp[3]  = 8'($urandom_range(1, 6));
    op_base[1] = 8'($urandom);
    op_exp[1]  = 8'($urandom_range(1, 6));
    d3 = ref_pow(op_base[3], op_exp[3]);
    d1 = ref_pow(op_base[1], op_exp[1]);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    eng_delay  = 4;
    load_ops();
    req_valid = 4'b1000;
    pred = ref_pick(model_ptr, 4'b1000);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got || req_ready !== (4'd1 << pred)) begin
      tests_failed++;
      $display("FAIL bp_grant: req_ready=%b required=%b", req_ready, 4'd1 << pred);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    model_ptr = (pred + 1) % 4;
    ready_ok  = 1'b1;
    stable_ok = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) ready_ok = 1'b0;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_id !== 2'(pred) || resp_data !== d3 || resp_cycles !== 16'd4)
        stable_ok = 1'b0;
      if (req_ready != 4'd0) ready_ok = 1'b0;
    end
    tests_run++;
    if (!seen || !stable_ok) begin
      tests_failed++;
      $display("FAIL bp_hold: seen=%0d id=%0d data=%0d cycles=%0d required id=%0d data=%0d cycles=4",
               seen, resp_id, resp_data, resp_cycles, pred, d3);
    end
    tests_run++;
    if (!ready_ok) begin
      tests_failed++;
      $display("FAIL bp_no_grant: req_ready went nonzero while busy, required 0000");
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pred = ref_pick(model_ptr, 4'b0010);
    tests_run++;
    if (req_ready !== (4'd1 << pred) || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_resume: req_ready=%b resp_valid=%b required %b and 0", req_ready, resp_valid, 4'd1 << pred);
    end
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    model_ptr = (pred + 1) % 4;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || resp_id !== 2'(pred) || resp_data !== d1) begin
      tests_failed++;
      $display("FAIL bp_second: seen=%0d id=%0d data=%0d required id=%0d data=%0d", seen, resp_id, resp_data, pred, d1);
    end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 4; i++) begin
        op_base[i] = 8'($urandom);
        op_exp[i]  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      end
      mask = 4'($urandom_range(1, 15));
      run_txn(mask, int'($urandom_range(1, 6)));
    end
  endtask

  task automatic test_spurious();
    @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err_spurious !== 1'b1 || resp_valid !== 1'b0 || eng_start !== 1'b0 || req_ready !== 4'd0) begin
      tests_failed++;
      $display("FAIL spurious_flag: err=%b resp_valid=%b eng_start=%b required 1,0,0", err_spurious, resp_valid, eng_start);
    end
    op_base[0] = 8'($urandom);
    op_exp[0]  = 8'd2;
    run_txn(4'b0001, 3);
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("FAIL spurious_sticky: err=%b required 1", err_spurious);
    end
  endtask

  task automatic test_saturation();
    op_base[2] = 8'd5;
    op_exp[2]  = 8'd3;
    run_txn(4'b0100, 70000);
  endtask

  task automatic test_reset_mid();
    bit got;
    op_base[0] = 8'd2;
    op_exp[0]  = 8'd7;
    @(posedge clk);
    #1;
    eng_delay = 50;
    load_ops();
    req_valid = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (!got || {req_ready, resp_valid, resp_id, resp_data, resp_cycles, eng_start, eng_base, eng_exp, err_spurious} !== 49'd0
        || dut.ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got=%0d data=%0d eng_base=%0d err=%b ptr=%0d required all 0",
               got, resp_data, eng_base, err_spurious, dut.ptr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    op_base[1] = 8'd3;
    op_exp[1]  = 8'd4;
    run_txn(4'b0010, 5);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_ptr    = 0;
    rst          = 1'b1;
    req_valid    = 4'd0;
    req_base     = 32'd0;
    req_exp      = 32'd0;
    resp_ready   = 1'b1;
    spur_done    = 1'b0;
    eng_delay    = 1;
    for (int i = 0; i < 4; i++) begin
      op_base[i] = 8'd0;
      op_exp[i]  = 8'd0;
    end
    test_reset();
    test_fairness();
    test_single();
    test_exp_zero();
    test_backpressure();
    test_random();
    test_spurious();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
